vend_controller: RTL
====================

Name: vend_controller

Overview:
- Sequencing controller for the vending machine datapath.
- Accumulates inserted coin credit and arbitrates product selections against that credit.
- Issues one-cycle vend strobes and the running total to the change-calculation unit.
- Handshakes with the product dispenser, then pays change or refunds one unit per cycle.

Parameters:
W, 4, credit/coin datapath width in bits
PRICE_A, 2, price of product A in credit units
PRICE_B, 3, price of product B in credit units
MAX_CREDIT, 15, highest credit accepted; must be <= 2**W-1

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
coin_valid  input  1  one-cycle strobe: a coin is presented
coin_value  input  W  value of presented coin; 0 is treated as invalid
sel_a  input  1  one-cycle request for product A
sel_b  input  1  one-cycle request for product B
cancel  input  1  one-cycle request to refund all credit
disp_ack  input  1  dispenser has delivered the product
credit  output  W  current credit; drives the change unit's total input
vend_a  output  1  one-cycle strobe to the change unit, product A sold
vend_b  output  1  one-cycle strobe to the change unit, product B sold
dispense_a  output  1  held high until disp_ack
dispense_b  output  1  held high until disp_ack
change_pulse  output  1  one credit unit returned this cycle
coin_reject  output  1  one-cycle: coin returned unaccepted
deny  output  1  one-cycle: selection refused, insufficient credit
busy  output  1  high in DISPENSE or PAYOUT

Behaviour:
- Reset: state IDLE, every output 0, internal change register 0. All outputs are registered, so every response appears one clock after its cause.
- States: IDLE (credit==0), CREDIT (credit>0, accepting), DISPENSE, PAYOUT.
- Same-cycle priority in IDLE/CREDIT: cancel > sel_a > sel_b > coin_valid.
  - A coin arriving in the same cycle as a cancel or an accepted selection gets coin_reject.
  - A coin arriving in the same cycle as a denied selection is still processed normally.
- Coin, in IDLE/CREDIT: compute sum = credit + coin_value in W+1 bits.
  - If coin_value != 0 and sum <= MAX_CREDIT: credit <= sum, go to CREDIT.
  - Otherwise: coin_reject pulses and credit is unchanged.
- Coins presented in DISPENSE or PAYOUT are always rejected.
- sel_a, in IDLE/CREDIT:
  - If credit >= PRICE_A: vend_a pulses for one cycle, dispense_a <= 1, change register <= credit - PRICE_A, go to DISPENSE.
  - credit holds its pre-sale value during the vend_a cycle so the change unit samples the correct total.
- sel_a with credit < PRICE_A: deny pulses and state is unchanged.
- sel_b: same rules as sel_a, using PRICE_B, vend_b and dispense_b.
- cancel:
  - In CREDIT: go to PAYOUT; the whole of credit is refunded.
  - In IDLE: no effect.
  - In DISPENSE or PAYOUT: ignored.
- sel_a/sel_b in DISPENSE or PAYOUT: ignored; no deny pulse.
- DISPENSE: dispense_x stays high, with no timeout, until disp_ack is sampled. On that cycle:
  - dispense_x <= 0 and credit <= change register.
  - If change == 0, go to IDLE; otherwise go to PAYOUT.
  - disp_ack outside DISPENSE is ignored.
- PAYOUT: each cycle change_pulse = 1 and credit decrements by 1.
  - The cycle that takes credit from 1 to 0 moves the state to IDLE.
  - N units of change produce exactly N consecutive change_pulse cycles, then change_pulse drops.
- Arithmetic: subtraction happens only after a >= comparison, so there is no underflow. credit never exceeds MAX_CREDIT.
- Reset asserted mid-operation: everything returns to reset values immediately. Pending change is lost and dispense_x drops.

Decomposition:
- Shared package vend_pkg holds:
  - state enum {IDLE, CREDIT, DISPENSE, PAYOUT}
  - default prices and MAX_CREDIT constants
  - a product-select enum {PROD_NONE, PROD_A, PROD_B}
- One sub-module is natural: vend_credit_reg, the credit accumulator. It provides saturation check, load, decrement, and reject/accept flags.
- The FSM stays in vend_controller.

Test Plan:
- Coins 1,2 then sel_b -> credit 1,3; vend_b pulse with credit=3; dispense_b high until disp_ack; then IDLE with no change_pulse.
- Coins 5,2 then sel_a, disp_ack after 3 cycles -> vend_a with credit=7; after ack credit=5; exactly 5 change_pulse cycles; credit counts 5→0; IDLE.
- Credit 1, sel_a -> deny pulse, credit stays 1, state CREDIT; then coin 2 and sel_a -> accepted, change 1 → one change_pulse.
- Credit 14, coin 2 -> coin_reject, credit 14; coin 1 -> credit 15; cancel -> 15 change_pulse cycles, coin during payout rejected, sel_a ignored.
- Same cycle sel_a and coin 2 with credit 4 -> vend_a, coin_reject, change 2; same cycle cancel and sel_b with credit 3 -> refund 3 pulses, no vend_b.
- Reset asserted in DISPENSE and again mid-PAYOUT -> all outputs 0 asynchronously; credit 0; IDLE after release; next coin 1 → credit 1.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending machine controller slice.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        PAYOUT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PROD_NONE = 2'd0,
        PROD_A    = 2'd1,
        PROD_B    = 2'd2
    } prod_t;

    typedef enum logic [1:0] {
        CR_HOLD = 2'd0,
        CR_ADD  = 2'd1,
        CR_LOAD = 2'd2,
        CR_DEC  = 2'd3
    } credit_op_t;

    localparam int DEF_W          = 4;
    localparam int DEF_PRICE_A    = 2;
    localparam int DEF_PRICE_B    = 3;
    localparam int DEF_MAX_CREDIT = 15;

endpackage

// File: rtl/vend_if.sv
// Request/response bundle between the vending front panel, dispenser and controller.
interface vend_if #(parameter int W = 4) ();

    logic         coin_valid;
    logic [W-1:0] coin_value;
    logic         sel_a;
    logic         sel_b;
    logic         cancel;
    logic         disp_ack;
    logic [W-1:0] credit;
    logic         vend_a;
    logic         vend_b;
    logic         dispense_a;
    logic         dispense_b;
    logic         change_pulse;
    logic         coin_reject;
    logic         deny;
    logic         busy;

    modport master (
        output coin_valid, coin_value, sel_a, sel_b, cancel, disp_ack,
        input  credit, vend_a, vend_b, dispense_a, dispense_b,
               change_pulse, coin_reject, deny, busy
    );

    modport slave (
        input  coin_valid, coin_value, sel_a, sel_b, cancel, disp_ack,
        output credit, vend_a, vend_b, dispense_a, dispense_b,
               change_pulse, coin_reject, deny, busy
    );

endinterface

// File: rtl/vend_credit_reg.sv
// Credit accumulator: add with saturation check, load of change, and unit decrement.
module vend_credit_reg
    import vend_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic         clk,
    input  logic         reset,
    input  credit_op_t   op,
    input  logic [W-1:0] coin_value,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] credit,
    output logic         coin_ok
);

    localparam logic [W:0] MAX_S = (W+1)'(MAX_CREDIT);

    logic [W-1:0] credit_r;
    logic [W:0]   sum_s;

    // Coin acceptance: nonzero and the widened sum stays within the ceiling.
    always_comb begin
        sum_s   = {1'b0, credit_r} + {1'b0, coin_value};
        coin_ok = (coin_value != {W{1'b0}}) && (sum_s <= MAX_S);
    end

    // Credit register update selected by the controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_r <= {W{1'b0}};
        end else begin
            case (op)
                CR_ADD:  credit_r <= sum_s[W-1:0];
                CR_LOAD: credit_r <= load_value;
                CR_DEC:  credit_r <= credit_r - W'(1);
                CR_HOLD: credit_r <= credit_r;
                default: credit_r <= credit_r;
            endcase
        end
    end

    assign credit = credit_r;

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, selection arbitration, dispenser handshake
// and one-unit-per-cycle change/refund payout. All outputs are registered.
module vend_controller
    import vend_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int PRICE_A    = DEF_PRICE_A,
    parameter int PRICE_B    = DEF_PRICE_B,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic  clk,
    input  logic  reset,
    vend_if.slave bus
);

    state_t       state_r;
    logic [W-1:0] change_r;
    logic         vend_a_r, vend_b_r, dispense_a_r, dispense_b_r;
    logic         change_pulse_r, coin_reject_r, deny_r, busy_r;

    logic [W-1:0] credit_s;
    logic         coin_ok_s;
    credit_op_t   credit_op_s;
    logic         accepting_s, cancel_go_s, sel_req_s, afford_s;
    logic         sale_s, deny_s, coin_accept_s, coin_reject_s;
    logic [W-1:0] price_s;
    prod_t        sale_prod_s;

    vend_credit_reg #(
        .W          (W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk        (clk),
        .reset      (reset),
        .op         (credit_op_s),
        .coin_value (bus.coin_value),
        .load_value (change_r),
        .credit     (credit_s),
        .coin_ok    (coin_ok_s)
    );

    // Same-cycle arbitration: cancel, then sel_a, then sel_b, then coin.
    always_comb begin
        accepting_s = (state_r == IDLE) || (state_r == CREDIT);
        cancel_go_s = (state_r == CREDIT) && bus.cancel;
        sel_req_s   = accepting_s && !cancel_go_s && (bus.sel_a || bus.sel_b);
        if (bus.sel_a) begin
            price_s = W'(PRICE_A);
        end else begin
            price_s = W'(PRICE_B);
        end
        afford_s = (credit_s >= price_s);
        sale_s   = sel_req_s && afford_s;
        deny_s   = sel_req_s && !afford_s;
        if (!sale_s) begin
            sale_prod_s = PROD_NONE;
        end else if (bus.sel_a) begin
            sale_prod_s = PROD_A;
        end else begin
            sale_prod_s = PROD_B;
        end
        // A denied selection does not consume the coin; an accepted one does.
        coin_accept_s = accepting_s && bus.coin_valid && !cancel_go_s && !sale_s && coin_ok_s;
        coin_reject_s = bus.coin_valid && !coin_accept_s;
        if ((state_r == DISPENSE) && bus.disp_ack) begin
            credit_op_s = CR_LOAD;
        end else if (state_r == PAYOUT) begin
            credit_op_s = CR_DEC;
        end else if (coin_accept_s) begin
            credit_op_s = CR_ADD;
        end else begin
            credit_op_s = CR_HOLD;
        end
    end

    // State machine with registered strobes and handshake levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            change_r       <= {W{1'b0}};
            vend_a_r       <= 1'b0;
            vend_b_r       <= 1'b0;
            dispense_a_r   <= 1'b0;
            dispense_b_r   <= 1'b0;
            change_pulse_r <= 1'b0;
            coin_reject_r  <= 1'b0;
            deny_r         <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            vend_a_r       <= 1'b0;
            vend_b_r       <= 1'b0;
            change_pulse_r <= 1'b0;
            coin_reject_r  <= coin_reject_s;
            deny_r         <= deny_s;
            case (state_r)
                IDLE, CREDIT: begin
                    if (cancel_go_s) begin
                        state_r <= PAYOUT;
                        busy_r  <= 1'b1;
                    end else if (sale_prod_s != PROD_NONE) begin
                        state_r      <= DISPENSE;
                        busy_r       <= 1'b1;
                        change_r     <= credit_s - price_s;
                        vend_a_r     <= (sale_prod_s == PROD_A);
                        vend_b_r     <= (sale_prod_s == PROD_B);
                        dispense_a_r <= (sale_prod_s == PROD_A);
                        dispense_b_r <= (sale_prod_s == PROD_B);
                    end else if (coin_accept_s) begin
                        state_r <= CREDIT;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DISPENSE: begin
                    if (bus.disp_ack) begin
                        dispense_a_r <= 1'b0;
                        dispense_b_r <= 1'b0;
                        if (change_r == {W{1'b0}}) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= PAYOUT;
                        end
                    end else begin
                        state_r <= DISPENSE;
                    end
                end
                PAYOUT: begin
                    change_pulse_r <= 1'b1;
                    if (credit_s == W'(1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= PAYOUT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.credit       = credit_s;
    assign bus.vend_a       = vend_a_r;
    assign bus.vend_b       = vend_b_r;
    assign bus.dispense_a   = dispense_a_r;
    assign bus.dispense_b   = dispense_b_r;
    assign bus.change_pulse = change_pulse_r;
    assign bus.coin_reject  = coin_reject_r;
    assign bus.deny         = deny_r;
    assign bus.busy         = busy_r;

endmodule
